ysyx_22041071_imem_rsp: RTL
===========================

YSYX_22041071_IMEM_RSP -- requirements
Module: ysyx_22041071_imem_rsp

Interface
REQ-001 SHALL have parameter LATENCY, 1, wait cycles before memory read; legal 1..15.
REQ-002 SHALL have parameter START_ADDR, 64'h8000_0000, base of instruction memory.
REQ-003 SHALL have parameter MEM_BYTES, 64'h0800_0000, size of the addressable region.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, fetch request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid is also high.
REQ-008 SHALL have port req_addr, input, 64, fetch PC.
REQ-009 SHALL have port flush, input, 1, discard any in-flight or pending response.
REQ-010 SHALL have port resp_valid, output, 1, response present.
REQ-011 SHALL have port resp_ready, input, 1, consumer accepts response.
REQ-012 SHALL have port resp_pc, output, 64, PC of the response.
REQ-013 SHALL have port resp_ins, output, 32, instruction word.
REQ-014 SHALL have port resp_err, output, 1, misaligned or out-of-range fetch.
REQ-015 SHALL have ports mem_en (output, 1), mem_ridx (output, 64) and mem_rdata (input, 64) forming a synchronous-read 64-bit memory port; mem_rdata is valid the cycle after mem_en.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, DATA and RESP.
REQ-017 SHALL drive req_ready = !flush && (IDLE || (RESP && resp_ready)).
REQ-018 On accept of a legal address, SHALL latch req_addr, load the counter with LATENCY-1 and enter WAIT.
REQ-019 SHALL treat an address as illegal if req_addr[1:0]!=0, req_addr<START_ADDR, or req_addr>=START_ADDR+MEM_BYTES.
REQ-020 On accept of an illegal address, SHALL enter RESP on the next edge with resp_err=1 and resp_ins=0, and SHALL NOT assert mem_en.
REQ-021 In WAIT, SHALL decrement the counter each cycle.
REQ-022 In WAIT, when the counter is 0, SHALL assert mem_en for exactly one cycle with mem_ridx=(addr-START_ADDR)>>3, then enter DATA.
REQ-023 In DATA, SHALL capture resp_ins = addr[2] ? mem_rdata[63:32] : mem_rdata[31:0], with resp_pc=addr and resp_err=0, then enter RESP.
REQ-024 For a legal address, resp_valid SHALL rise exactly LATENCY+1 edges after the accepting edge.
REQ-025 In RESP, resp_valid=1 and resp_pc, resp_ins and resp_err SHALL hold stable until resp_valid && resp_ready.
REQ-026 On a RESP handshake with no new accept, the FSM SHALL return to IDLE and clear resp_valid.
REQ-027 On a RESP handshake with a simultaneous new accept, the FSM SHALL proceed directly per REQ-018/REQ-020 with no idle cycle.
REQ-028 flush SHALL have priority over every other event: next state IDLE, resp_valid=0, no request accepted in that cycle, and no mem_en issued in that cycle.
REQ-029 resp_valid SHALL be low in IDLE, WAIT and DATA.
REQ-030 At most one request SHALL be outstanding at any time.

Reset
REQ-031 While reset is low, SHALL force state IDLE, counter 0, resp_valid 0, resp_pc 0, resp_ins 0, resp_err 0, mem_en 0, mem_ridx 0 and req_ready 0.
REQ-032 Reset asserted mid-transaction SHALL discard the transaction; the first cycle after release SHALL present req_ready=1.

Structure
REQ-033 START_ADDR default, state encodings, and the address (64) and instruction (32) widths SHALL live in the shared define file.
REQ-034 The wait counter SHALL be a sub-module, ysyx_22041071_lat_cnt (load, decrement, zero flag).

Verification
REQ-035 LATENCY=1, req_addr=0x8000_0004, mem_rdata=0x1111_2222_3333_4444 -> mem_ridx=0 one cycle after accept; resp_valid two edges after accept; resp_ins=0x1111_2222, resp_err=0.
REQ-036 req_addr=0x8000_0002 -> resp_valid on the next edge, resp_err=1, resp_ins=0, mem_en never asserted.
REQ-037 resp_ready held low 5 cycles in RESP -> resp_valid and data held stable; releasing resp_ready with req_valid high and req_addr=0x8000_0008 -> new request accepted on the same edge.
REQ-038 flush asserted in WAIT with LATENCY=3 -> mem_en never pulses, resp_valid stays 0, req_ready=1 in the following cycle.
REQ-039 reset pulsed low during DATA -> all outputs 0 immediately; after release, req_ready=1 and a fresh request completes normally.
REQ-040 req_addr=START_ADDR+MEM_BYTES -> resp_err=1; req_addr=START_ADDR+MEM_BYTES-4 -> legal, resp_err=0.

Source files
------------

// File: rtl/ysyx_22041071_imem_rsp_pkg.sv
// Shared definitions for the instruction-memory response block.
// Holds the address and instruction widths, the wait-counter width, the
// default memory window, the FSM state encoding and the address legality rule.
package ysyx_22041071_imem_rsp_pkg;

  localparam int ADDR_W = 64;
  localparam int INS_W  = 32;
  // LATENCY is limited to 1..15, so LATENCY-1 always fits in four bits.
  localparam int CNT_W  = 4;

  localparam logic [ADDR_W-1:0] START_ADDR_DEF = 64'h8000_0000;
  localparam logic [ADDR_W-1:0] MEM_BYTES_DEF  = 64'h0800_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } imem_state_e;

  // The window check uses the offset from the base, so base+size never has
  // to be formed and cannot wrap at the top of the 64-bit space.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] bytes);
    logic [ADDR_W-1:0] off;
    off = addr - base;
    return (addr[1:0] == 2'b00) && (addr >= base) && (off < bytes);
  endfunction

endpackage

// File: rtl/ysyx_22041071_imem_rsp_lat_cnt.sv
// Down-counter that times the wait before the memory read.
// Ports:
//   clk, reset   - clock and asynchronous active-low reset (clears count)
//   load         - load load_val (has priority over dec)
//   load_val     - value to load
//   dec          - decrement by one; the count stops at zero
//   zero         - count is zero
module ysyx_22041071_lat_cnt
  import ysyx_22041071_imem_rsp_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ysyx_22041071_imem_rsp.sv
// Instruction fetch responder: accepts one fetch at a time, waits LATENCY
// cycles, reads a 64-bit word from a synchronous memory and returns the
// selected 32-bit instruction. Misaligned or out-of-window fetches answer
// immediately with resp_err set and never touch the memory.
// Ports:
//   clk, reset                       - clock, asynchronous active-low reset
//   req_valid, req_ready, req_addr   - fetch request handshake and PC
//   flush                            - drop any pending work, go idle
//   resp_valid, resp_ready           - response handshake
//   resp_pc, resp_ins, resp_err      - response payload
//   mem_en, mem_ridx, mem_rdata      - synchronous-read memory port
//                                      (data valid the cycle after mem_en)
module ysyx_22041071_imem_rsp
  import ysyx_22041071_imem_rsp_pkg::*;
#(
  parameter int                LATENCY    = 1,
  parameter logic [ADDR_W-1:0] START_ADDR = START_ADDR_DEF,
  parameter logic [ADDR_W-1:0] MEM_BYTES  = MEM_BYTES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] resp_pc,
  output logic [INS_W-1:0]  resp_ins,
  output logic              resp_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_ridx,
  input  logic [63:0]       mem_rdata
);

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_off;
  logic              req_legal;
  logic              accept;
  logic              cnt_zero;

  assign req_legal = addr_legal(req_addr, START_ADDR, MEM_BYTES);

  // Gated by reset so the block advertises nothing while held in reset.
  assign req_ready = reset && !flush &&
                     ((state_q == S_IDLE) || ((state_q == S_RESP) && resp_ready));
  assign accept    = req_valid && req_ready;

  assign resp_valid = (state_q == S_RESP);

  // The read is issued in the last wait cycle; flush suppresses it.
  assign mem_en   = (state_q == S_WAIT) && cnt_zero && !flush;
  assign addr_off = addr_q - START_ADDR;
  assign mem_ridx = mem_en ? (addr_off >> 3) : '0;

  ysyx_22041071_lat_cnt #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && req_legal),
    .load_val (CNT_W'(LATENCY - 1)),
    .dec      (state_q == S_WAIT),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_legal ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_zero) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        // A handshake may coincide with a new accept: go straight on.
        if (resp_ready) begin
          if (accept) begin
            state_d = req_legal ? S_WAIT : S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // Payload only changes on accept (error responses) or on the data cycle,
  // so it stays stable for the whole RESP state until the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      resp_pc  <= '0;
      resp_ins <= '0;
      resp_err <= 1'b0;
    end else if (accept) begin
      addr_q <= req_addr;
      if (!req_legal) begin
        resp_pc  <= req_addr;
        resp_ins <= '0;
        resp_err <= 1'b1;
      end
    end else if ((state_q == S_DATA) && !flush) begin
      resp_pc  <= addr_q;
      resp_ins <= addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
      resp_err <= 1'b0;
    end
  end

endmodule
